// File: rtl/exc_flush_if.sv
// exc_flush_if: MEM/CP0/bus/fetch signals exchanged with exc_flush_ctrl.
// EXC_PERF_CNT_EN adds the exc_count/eret_count performance counters.
interface exc_flush_if;
    logic        mem_valid;
    logic        mem_exc;
    logic        mem_eret;
    logic        sr_bev;
    logic [31:0] cp0_epc;
    logic        bus_busy;
    logic        fetch_ready;
    logic        stall_all;
    logic        cp0_commit;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;
    logic        drain_timeout;
`ifdef EXC_PERF_CNT_EN
    logic [31:0] exc_count;
    logic [31:0] eret_count;
    modport slave (
        input  mem_valid, mem_exc, mem_eret, sr_bev, cp0_epc, bus_busy, fetch_ready,
        output stall_all, cp0_commit, flush, redirect_valid, redirect_pc, busy, drain_timeout,
        output exc_count, eret_count
    );
    modport master (
        output mem_valid, mem_exc, mem_eret, sr_bev, cp0_epc, bus_busy, fetch_ready,
        input  stall_all, cp0_commit, flush, redirect_valid, redirect_pc, busy, drain_timeout,
        input  exc_count, eret_count
    );
`else
    modport slave (
        input  mem_valid, mem_exc, mem_eret, sr_bev, cp0_epc, bus_busy, fetch_ready,
        output stall_all, cp0_commit, flush, redirect_valid, redirect_pc, busy, drain_timeout
    );
    modport master (
        output mem_valid, mem_exc, mem_eret, sr_bev, cp0_epc, bus_busy, fetch_ready,
        input  stall_all, cp0_commit, flush, redirect_valid, redirect_pc, busy, drain_timeout
    );
`endif
endinterface

// File: rtl/exc_flush_ctrl.sv
// exc_flush_ctrl: sequences exception/ERET commit: stall, drain bus, commit+flush, redirect fetch.
// Optional EXC_PERF_CNT_EN adds per-kind commit counters.
module exc_flush_ctrl #(
    parameter int          DRAIN_TIMEOUT = 15,
    parameter logic [31:0] EXC_VEC_BOOT  = 32'hBFC00380,
    parameter logic [31:0] EXC_VEC_NORM  = 32'h80000180
) (
    input logic        clk,
    input logic        resetn,
    exc_flush_if.slave ctl
);
    typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIRECT} state_t;

    localparam logic [7:0] L_TO    = 8'(DRAIN_TIMEOUT);
    localparam logic [7:0] L_TO_M1 = 8'(DRAIN_TIMEOUT - 1);

    state_t      r_state, w_next;
    logic [7:0]  r_cnt;
    logic [31:0] r_target;
    logic        r_kind_exc;
    logic        r_timeout;
    logic        w_req, w_timeout;
    logic        w_stall, w_commit, w_flush, w_rvalid;

    assign w_req = ctl.mem_valid & (ctl.mem_exc | ctl.mem_eret);
    // r_cnt counts DRAIN cycles already spent, so the current one is r_cnt+1
    assign w_timeout = ctl.bus_busy && (r_cnt == L_TO_M1);

    always_comb begin
        w_next   = r_state;
        w_stall  = 1'b0;
        w_commit = 1'b0;
        w_flush  = 1'b0;
        w_rvalid = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_stall = w_req;
                w_next  = w_req ? DRAIN : IDLE;
            end
            DRAIN: begin
                w_stall = 1'b1;
                w_next  = (!ctl.bus_busy || w_timeout) ? COMMIT : DRAIN;
            end
            COMMIT: begin
                w_stall  = 1'b1;
                w_commit = 1'b1;
                w_flush  = 1'b1;
                w_next   = REDIRECT;
            end
            REDIRECT: begin
                w_stall  = 1'b1;
                w_rvalid = 1'b1;
                w_next   = ctl.fetch_ready ? IDLE : REDIRECT;
            end
            default: w_next = IDLE;
        endcase
        if (!resetn) begin
            w_next   = IDLE;
            w_stall  = 1'b0;
            w_commit = 1'b0;
            w_flush  = 1'b0;
            w_rvalid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_target   <= '0;
            r_kind_exc <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_req) begin
                r_kind_exc <= ctl.mem_exc;
                r_target   <= ctl.mem_exc ? (ctl.sr_bev ? EXC_VEC_BOOT : EXC_VEC_NORM) : ctl.cp0_epc;
                r_cnt      <= '0;
            end
            if (r_state == DRAIN) begin
                r_cnt <= (r_cnt == L_TO) ? r_cnt : r_cnt + 8'd1;
                if (w_timeout)
                    r_timeout <= 1'b1;
            end
        end
    end

    assign ctl.stall_all      = w_stall;
    assign ctl.cp0_commit     = w_commit;
    assign ctl.flush          = w_flush;
    assign ctl.redirect_valid = w_rvalid;
    assign ctl.redirect_pc    = r_target;
    assign ctl.busy           = resetn && (r_state != IDLE);
    assign ctl.drain_timeout  = r_timeout;

`ifdef EXC_PERF_CNT_EN
    logic [31:0] r_exc_count, r_eret_count;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_exc_count  <= '0;
            r_eret_count <= '0;
        end else if (r_state == COMMIT) begin
            if (r_kind_exc)
                r_exc_count <= r_exc_count + 32'd1;
            else
                r_eret_count <= r_eret_count + 32'd1;
        end
    end

    assign ctl.exc_count  = r_exc_count;
    assign ctl.eret_count = r_eret_count;
`endif
endmodule

// File: tb/tb_exc_flush_ctrl.sv
// tb_exc_flush_ctrl: directed checks of exc_flush_ctrl sequencing, drain timeout, backpressure and reset.
module tb_exc_flush_ctrl;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    exc_flush_if ctl ();

    exc_flush_ctrl dut (
        .clk    (clk),
        .resetn (resetn),
        .ctl    (ctl)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs;
        ctl.mem_valid   = 1'b0;
        ctl.mem_exc     = 1'b0;
        ctl.mem_eret    = 1'b0;
        ctl.sr_bev      = 1'b0;
        ctl.cp0_epc     = 32'h0;
        ctl.bus_busy    = 1'b0;
        ctl.fetch_ready = 1'b1;
    endtask

    // Fast transaction with idle bus and ready fetch; returns to IDLE.
    task automatic do_req(input logic exc, input logic eret, input logic bev, input logic [31:0] epc);
        ctl.mem_valid = 1'b1;
        ctl.mem_exc   = exc;
        ctl.mem_eret  = eret;
        ctl.sr_bev    = bev;
        ctl.cp0_epc   = epc;
        tick;
        tick;
        ctl.mem_valid = 1'b0;
        tick;
        tick;
    endtask

    task automatic test_reset;
        idle_inputs();
        ctl.mem_valid = 1'b1;
        ctl.mem_exc   = 1'b1;
        resetn = 1'b0;
        tick;
        tick;
        #1;
        checks++;
        if ({ctl.stall_all, ctl.cp0_commit, ctl.flush, ctl.redirect_valid, ctl.busy, ctl.drain_timeout} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 000000",
                     {ctl.stall_all, ctl.cp0_commit, ctl.flush, ctl.redirect_valid, ctl.busy, ctl.drain_timeout});
        end
        checks++;
        if (ctl.redirect_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_pc: got %h want 00000000", ctl.redirect_pc);
        end
        idle_inputs();
        resetn = 1'b1;
        tick;
    endtask

    task automatic test_exc_idle;
        ctl.mem_valid = 1'b1;
        ctl.mem_exc   = 1'b1;
        ctl.sr_bev    = 1'b0;
        #1;
        checks++;
        if (ctl.stall_all !== 1'b1 || ctl.busy !== 1'b0) begin
            errors++;
            $display("FAIL exc_req_cycle: stall=%b busy=%b want stall=1 busy=0", ctl.stall_all, ctl.busy);
        end
        tick;
        checks++;
        if (ctl.busy !== 1'b1 || ctl.cp0_commit !== 1'b0 || ctl.stall_all !== 1'b1) begin
            errors++;
            $display("FAIL exc_drain: busy=%b commit=%b stall=%b want 1 0 1", ctl.busy, ctl.cp0_commit, ctl.stall_all);
        end
        tick;
        checks++;
        if (ctl.cp0_commit !== 1'b1 || ctl.flush !== 1'b1 || ctl.redirect_valid !== 1'b0) begin
            errors++;
            $display("FAIL exc_commit: commit=%b flush=%b rv=%b want 1 1 0", ctl.cp0_commit, ctl.flush, ctl.redirect_valid);
        end
        ctl.mem_valid = 1'b0;
        tick;
        checks++;
        if (ctl.redirect_valid !== 1'b1 || ctl.redirect_pc !== 32'h80000180 || ctl.cp0_commit !== 1'b0) begin
            errors++;
            $display("FAIL exc_redirect: rv=%b pc=%h commit=%b want 1 80000180 0", ctl.redirect_valid, ctl.redirect_pc, ctl.cp0_commit);
        end
        tick;
        checks++;
        if (ctl.stall_all !== 1'b0 || ctl.busy !== 1'b0 || ctl.redirect_valid !== 1'b0) begin
            errors++;
            $display("FAIL exc_done: stall=%b busy=%b rv=%b want 0 0 0", ctl.stall_all, ctl.busy, ctl.redirect_valid);
        end
        idle_inputs();
    endtask

    task automatic test_eret_drain;
        int n = 0;
        ctl.mem_valid = 1'b1;
        ctl.mem_eret  = 1'b1;
        ctl.cp0_epc   = 32'hBFC00104;
        ctl.bus_busy  = 1'b1;
        for (int i = 1; i <= 30 && n == 0; i++) begin
            tick;
            if (i == 5) ctl.bus_busy = 1'b0;
            #1;
            if (ctl.cp0_commit) n = i;
        end
        checks++;
        if (n != 6) begin
            errors++;
            $display("FAIL eret_drain_len: commit at tick %0d want 6", n);
        end
        ctl.mem_valid = 1'b0;
        tick;
        checks++;
        if (ctl.redirect_pc !== 32'hBFC00104 || ctl.redirect_valid !== 1'b1) begin
            errors++;
            $display("FAIL eret_pc: pc=%h rv=%b want bfc00104 1", ctl.redirect_pc, ctl.redirect_valid);
        end
        checks++;
        if (ctl.drain_timeout !== 1'b0) begin
            errors++;
            $display("FAIL eret_no_timeout: got %b want 0", ctl.drain_timeout);
        end
        tick;
        idle_inputs();
    endtask

    task automatic test_both;
        ctl.mem_valid = 1'b1;
        ctl.mem_exc   = 1'b1;
        ctl.mem_eret  = 1'b1;
        ctl.sr_bev    = 1'b1;
        ctl.cp0_epc   = 32'h12345678;
        tick;
        tick;
        ctl.mem_valid = 1'b0;
        tick;
        checks++;
        if (ctl.redirect_pc !== 32'hBFC00380 || ctl.redirect_valid !== 1'b1) begin
            errors++;
            $display("FAIL both_pc: pc=%h rv=%b want bfc00380 1", ctl.redirect_pc, ctl.redirect_valid);
        end
        tick;
        idle_inputs();
`ifdef EXC_PERF_CNT_EN
        checks++;
        if (ctl.exc_count !== 32'd2 || ctl.eret_count !== 32'd1) begin
            errors++;
            $display("FAIL both_kind: exc=%0d eret=%0d want 2 1", ctl.exc_count, ctl.eret_count);
        end
`endif
    endtask

    task automatic test_timeout;
        int n = 0;
        ctl.mem_valid = 1'b1;
        ctl.mem_exc   = 1'b1;
        ctl.bus_busy  = 1'b1;
        for (int i = 1; i <= 40 && n == 0; i++) begin
            tick;
            if (i == 15) begin
                checks++;
                if (ctl.drain_timeout !== 1'b0 || ctl.cp0_commit !== 1'b0) begin
                    errors++;
                    $display("FAIL timeout_early: to=%b commit=%b want 0 0", ctl.drain_timeout, ctl.cp0_commit);
                end
            end
            if (ctl.cp0_commit) n = i;
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL timeout_len: commit at tick %0d want 16", n);
        end
        checks++;
        if (ctl.drain_timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_flag: got %b want 1", ctl.drain_timeout);
        end
        ctl.mem_valid = 1'b0;
        ctl.bus_busy  = 1'b0;
        tick;
        tick;
        tick;
        checks++;
        if (ctl.drain_timeout !== 1'b1 || ctl.busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_sticky: to=%b busy=%b want 1 0", ctl.drain_timeout, ctl.busy);
        end
        idle_inputs();
    endtask

    task automatic test_backpressure;
        int commits = 0;
        ctl.mem_valid   = 1'b1;
        ctl.mem_exc     = 1'b1;
        ctl.fetch_ready = 1'b0;
        tick;
        tick;
        if (ctl.cp0_commit) commits++;
        tick;
        for (int i = 0; i < 4; i++) begin
            ctl.sr_bev = 1'b1;
            #1;
            if (ctl.cp0_commit) commits++;
            checks++;
            if (ctl.redirect_valid !== 1'b1 || ctl.redirect_pc !== 32'h80000180) begin
                errors++;
                $display("FAIL bp_hold[%0d]: rv=%b pc=%h want 1 80000180", i, ctl.redirect_valid, ctl.redirect_pc);
            end
            if (i < 3) tick;
        end
        ctl.fetch_ready = 1'b1;
        ctl.mem_valid   = 1'b0;
        tick;
        if (ctl.cp0_commit) commits++;
        checks++;
        if (commits != 1 || ctl.busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_single_commit: commits=%0d busy=%b want 1 0", commits, ctl.busy);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_drain;
        ctl.mem_valid = 1'b1;
        ctl.mem_exc   = 1'b1;
        ctl.bus_busy  = 1'b1;
        tick;
        tick;
        resetn = 1'b0;
        #1;
        checks++;
        if ({ctl.stall_all, ctl.cp0_commit, ctl.flush, ctl.redirect_valid, ctl.busy} !== 5'b0) begin
            errors++;
            $display("FAIL rst_drain_during: got %b want 00000",
                     {ctl.stall_all, ctl.cp0_commit, ctl.flush, ctl.redirect_valid, ctl.busy});
        end
        ctl.mem_valid = 1'b0;
        tick;
        resetn = 1'b1;
        #1;
        checks++;
        if ({ctl.stall_all, ctl.cp0_commit, ctl.busy, ctl.drain_timeout} !== 4'b0 || ctl.redirect_pc !== 32'h0) begin
            errors++;
            $display("FAIL rst_drain_after: ctl=%b pc=%h want 0000 00000000",
                     {ctl.stall_all, ctl.cp0_commit, ctl.busy, ctl.drain_timeout}, ctl.redirect_pc);
        end
        tick;
        checks++;
        if (ctl.cp0_commit !== 1'b0 || ctl.busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_drain_idle: commit=%b busy=%b want 0 0", ctl.cp0_commit, ctl.busy);
        end
        idle_inputs();
    endtask

`ifdef EXC_PERF_CNT_EN
    task automatic test_perf;
        checks++;
        if (ctl.exc_count !== 32'd0 || ctl.eret_count !== 32'd0) begin
            errors++;
            $display("FAIL perf_reset: exc=%0d eret=%0d want 0 0", ctl.exc_count, ctl.eret_count);
        end
        for (int i = 0; i < 3; i++) do_req(1'b1, 1'b0, 1'b0, 32'h0);
        checks++;
        if (ctl.exc_count !== 32'd3 || ctl.eret_count !== 32'd0) begin
            errors++;
            $display("FAIL perf_three: exc=%0d eret=%0d want 3 0", ctl.exc_count, ctl.eret_count);
        end
    endtask
`endif

    task automatic test_back_to_back;
        do_req(1'b0, 1'b1, 1'b0, 32'h00400010);
        ctl.mem_valid = 1'b1;
        ctl.mem_eret  = 1'b1;
        ctl.cp0_epc   = 32'h00400020;
        #1;
        checks++;
        if (ctl.stall_all !== 1'b1 || ctl.redirect_pc !== 32'h00400010) begin
            errors++;
            $display("FAIL b2b_second_req: stall=%b pc=%h want 1 00400010", ctl.stall_all, ctl.redirect_pc);
        end
        tick;
        tick;
        ctl.mem_valid = 1'b0;
        tick;
        checks++;
        if (ctl.redirect_pc !== 32'h00400020 || ctl.redirect_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_pc: pc=%h rv=%b want 00400020 1", ctl.redirect_pc, ctl.redirect_valid);
        end
        tick;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_exc_idle();
        test_eret_drain();
        test_both();
        test_back_to_back();
        test_timeout();
        test_backpressure();
        test_reset_mid_drain();
`ifdef EXC_PERF_CNT_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
